convolution_procesor_ctrl: RTL

Control and address-generation FSM of the convolution processor. It sits directly downstream of the size-check AND gate, whose 1-bit `sizes_valid` result (both sizes non-zero) gates the start of a run. For a convolution Z = X * Y it sequences the X/Y memory read addresses, the accumulator clear/enable strobes and the Z memory write address/strobe. A single `done` pulse ends each run.

---
 rtl/convolution_procesor_ctrl_if.sv | 30 +++
 rtl/convolution_procesor_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/convolution_procesor_ctrl_if.sv
// Handshake and memory-control bundle between the convolution controller and its surroundings.
// The slave side is the controller; the master side drives run requests and sizes.
interface convolution_procesor_ctrl_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  start;
  logic                  sizes_valid;
  logic [ADDR_WIDTH:0]   size_x;
  logic [ADDR_WIDTH:0]   size_y;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] addr_x;
  logic [ADDR_WIDTH-1:0] addr_y;
  logic                  acc_clr;
  logic                  acc_en;
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   addr_z;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, sizes_valid, size_x, size_y,
    input  mem_rd_en, addr_x, addr_y, acc_clr, acc_en, wr_en, addr_z, busy, done, err
  );

  modport slave (
    input  start, sizes_valid, size_x, size_y,
    output mem_rd_en, addr_x, addr_y, acc_clr, acc_en, wr_en, addr_z, busy, done, err
  );
endinterface

// File: rtl/convolution_procesor_ctrl.sv
// Control and address generation for Z = X * Y: walks each output index i over its
// valid j range, strobing reads, accumulator clear/enable and the Z write.
module convolution_procesor_ctrl #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  convolution_procesor_ctrl_if.slave  bus
);
  localparam int CW = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0] MAX_SIZE = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         i_q, i_d;
  logic [ADDR_WIDTH-1:0] j_q, j_d;
  logic [ADDR_WIDTH:0]   sx_q, sx_d, sy_q, sy_d;
  logic                  acc_en_q, acc_en_d;
  logic                  err_q, err_d;

  logic [CW-1:0]         sx_w, sy_w, last_i, j_lo, j_hi, i_minus_j;
  logic                  start_ok;

  logic                  mem_rd_en_s, acc_clr_s, wr_en_s, busy_s, done_s;
  logic [ADDR_WIDTH-1:0] addr_x_s, addr_y_s;
  logic [ADDR_WIDTH:0]   addr_z_s;

  // j bounds for the current output index; all in CW bits so nothing wraps.
  always_comb begin
    sx_w      = CW'(sx_q);
    sy_w      = CW'(sy_q);
    last_i    = sx_w + sy_w - CW'(2);
    i_minus_j = i_q - CW'(j_q);
    if (i_q >= sy_w - CW'(1)) begin
      j_lo = i_q - (sy_w - CW'(1));
    end else begin
      j_lo = '0;
    end
    if (i_q < sx_w - CW'(1)) begin
      j_hi = i_q;
    end else begin
      j_hi = sx_w - CW'(1);
    end
    start_ok = bus.sizes_valid && (bus.size_x <= MAX_SIZE) && (bus.size_y <= MAX_SIZE);
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    err_d       = 1'b0;
    mem_rd_en_s = 1'b0;
    acc_clr_s   = 1'b0;
    wr_en_s     = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    addr_x_s    = '0;
    addr_y_s    = '0;
    addr_z_s    = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (start_ok) begin
            sx_d    = bus.size_x;
            sy_d    = bus.size_y;
            i_d     = '0;
            state_d = S_CLR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLR: begin
        busy_s    = 1'b1;
        acc_clr_s = 1'b1;
        j_d       = ADDR_WIDTH'(j_lo);
        state_d   = S_MAC;
      end
      S_MAC: begin
        busy_s      = 1'b1;
        mem_rd_en_s = 1'b1;
        addr_x_s    = j_q;
        addr_y_s    = ADDR_WIDTH'(i_minus_j);
        if (CW'(j_q) == j_hi) begin
          state_d = S_DRAIN;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_DRAIN: begin
        busy_s  = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        busy_s   = 1'b1;
        wr_en_s  = 1'b1;
        addr_z_s = (ADDR_WIDTH + 1)'(i_q);
        if (i_q == last_i) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + CW'(1);
          state_d = S_CLR;
        end
      end
      S_DONE: begin
        done_s  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // acc_en lags the read strobe by the RAM read latency.
    acc_en_d = mem_rd_en_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      acc_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      acc_en_q <= acc_en_d;
      err_q    <= err_d;
    end
  end

  assign bus.mem_rd_en = mem_rd_en_s;
  assign bus.addr_x    = addr_x_s;
  assign bus.addr_y    = addr_y_s;
  assign bus.acc_clr   = acc_clr_s;
  assign bus.acc_en    = acc_en_q;
  assign bus.wr_en     = wr_en_s;
  assign bus.addr_z    = addr_z_s;
  assign bus.busy      = busy_s;
  assign bus.done      = done_s;
  assign bus.err       = err_q;
endmodule
